result_line_packer: RTL and testbench

Downstream of the normalization stage in the matrix-multiplier AFU. Collects the 32-bit unum results that normalization emits one per cycle, qualified by its `finish` strobe, and packs LANES of them into one output line. Completed lines go into a small line FIFO that drains to the AFU write path through a valid/ready handshake. Per-line overflow and NaR (0x8000_0000) status is aggregated, and lines that cannot be buffered are counted as a sticky error.

---
 rtl/result_line_packer.sv | 157 +++++++++++++++
 tb/tb_result_line_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/result_line_packer.sv
// result_line_packer
// Packs 32-bit unum results from the normalization stage into lines of LANES
// words and buffers completed lines in a DEPTH-entry FIFO that drains through
// a valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   unum, overflow      result word and its overflow flag
//   finish              unum/overflow valid this cycle (never stalls)
//   flush               request to emit the current partial line
//   line_ready          downstream accepts the head line
//   line_valid          FIFO non-empty
//   line_data           head line, lane i = bits [32i+31:32i]
//   line_words          number of valid lanes in the head line
//   line_ovf, line_nar  head line status flags
//   full                FIFO holds DEPTH lines
//   err                 sticky, a completed line was dropped
//   lines_out           count of popped lines (wraps)

// One assembly lane. cur presents the lane as it will be pushed, i.e. with the
// word written this cycle already merged in.
module result_line_packer_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] cur
);
  logic [31:0] q;

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (we)    q <= d;
  end

  assign cur = we ? d : q;
endmodule

module result_line_packer #(
  parameter int LANES = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            unum,
  input  logic                   overflow,
  input  logic                   finish,
  input  logic                   flush,
  input  logic                   line_ready,
  output logic                   line_valid,
  output logic [32*LANES-1:0]    line_data,
  output logic [$clog2(LANES):0] line_words,
  output logic                   line_ovf,
  output logic                   line_nar,
  output logic                   full,
  output logic                   err,
  output logic [15:0]            lines_out
);
  localparam int IW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0]   NAR      = 32'h8000_0000;
  localparam logic [IW-1:0] LAST     = IW'(LANES - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  logic [IW-1:0] idx;
  logic          a_ovf, a_nar, flush_pend;
  logic [LANES-1:0][31:0] lane_cur;

  logic [DEPTH-1:0][32*LANES-1:0] f_data;
  logic [DEPTH-1:0][IW:0]         f_words;
  logic [DEPTH-1:0]               f_ovf, f_nar;
  logic [PW-1:0]                  wptr, rptr;
  logic [PW:0]                    count, count_nx;

  logic [IW:0] idx_after;
  logic fill_push, flush_svc, push, drop, clr, pop, accept, e_ovf, e_nar;

  // Fill level including the word arriving this cycle.
  assign idx_after = {1'b0, idx} + {{IW{1'b0}}, finish};
  assign fill_push = finish && (idx == LAST);
  assign pop       = line_valid & line_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign accept    = (count != CNT_FULL) | pop;
  // A flush arriving with a word is serviced at once; otherwise it waits a cycle
  // in flush_pend.
  assign flush_svc = (flush_pend | (flush & finish)) & (idx_after != '0) & accept;
  assign push      = (fill_push & accept) | flush_svc;
  assign drop      = fill_push & ~accept;
  // Assembly clears on every completed line, whether buffered or dropped.
  assign clr       = fill_push | flush_svc;
  assign e_ovf     = a_ovf | (finish & overflow);
  assign e_nar     = a_nar | (finish & (unum == NAR));
  assign count_nx  = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    result_line_packer_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .we  (finish && (idx == IW'(i))),
      .d   (unum),
      .cur (lane_cur[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      a_ovf      <= 1'b0;
      a_nar      <= 1'b0;
      flush_pend <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      line_valid <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      lines_out  <= '0;
    end else begin
      if (clr) begin
        idx   <= '0;
        a_ovf <= 1'b0;
        a_nar <= 1'b0;
      end else if (finish) begin
        idx   <= idx + 1'b1;
        a_ovf <= e_ovf;
        a_nar <= e_nar;
      end
      // Pending flush survives a full FIFO but dies with an empty assembly.
      flush_pend <= ~clr & (flush | flush_pend) & (idx_after != '0);
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr      <= rptr + 1'b1;
        lines_out <= lines_out + 16'd1;
      end
      count      <= count_nx;
      line_valid <= (count_nx != '0);
      full       <= (count_nx == CNT_FULL);
      if (drop) err <= 1'b1;
    end
  end

  // Storage needs no reset: head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wptr]  <= lane_cur;
      f_words[wptr] <= idx_after;
      f_ovf[wptr]   <= e_ovf;
      f_nar[wptr]   <= e_nar;
    end
  end

  assign line_data  = line_valid ? f_data[rptr]  : '0;
  assign line_words = line_valid ? f_words[rptr] : '0;
  assign line_ovf   = line_valid & f_ovf[rptr];
  assign line_nar   = line_valid & f_nar[rptr];
endmodule

// File: tb/tb_result_line_packer.sv
module tb_result_line_packer;
  localparam int LANES = 16;
  localparam int DEPTH = 4;
  localparam int IW    = $clog2(LANES);
  localparam int LW    = 32 * LANES;

  logic          clk = 1'b0, rst = 1'b1;
  logic [31:0]   unum = '0;
  logic          overflow = 1'b0, finish = 1'b0, flush = 1'b0, line_ready = 1'b1;
  logic          line_valid, line_ovf, line_nar, full, err;
  logic [LW-1:0] line_data;
  logic [IW:0]   line_words;
  logic [15:0]   lines_out;

  result_line_packer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .unum(unum), .overflow(overflow), .finish(finish),
    .flush(flush), .line_ready(line_ready), .line_valid(line_valid),
    .line_data(line_data), .line_words(line_words), .line_ovf(line_ovf),
    .line_nar(line_nar), .full(full), .err(err), .lines_out(lines_out)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [LW-1:0] got, logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the line under assembly is a queue of words; buffered
  // lines form the scoreboard, occupancy is tracked separately so the monitor
  // can retire entries on the observed handshake.
  typedef struct {
    logic [LW-1:0] data;
    int            words;
    bit            ovf;
    bit            nar;
  } line_t;

  logic [31:0] asmq[$];
  line_t       sb[$];
  bit          m_ovf, m_nar, m_pend, m_err;
  int          mcount;
  logic [15:0] m_lines;

  always @(posedge clk) begin : model
    bit    pop, acc, fillp, svc;
    int    n;
    line_t l;
    if (rst) begin
      asmq.delete(); sb.delete();
      m_ovf = 0; m_nar = 0; m_pend = 0; m_err = 0; mcount = 0; m_lines = '0;
    end else begin
      pop = (mcount > 0) && line_ready;
      acc = (mcount < DEPTH) || pop;
      if (finish) begin
        asmq.push_back(unum);
        m_ovf |= overflow;
        m_nar |= (unum == 32'h8000_0000);
      end
      n     = asmq.size();
      fillp = finish && (n == LANES);
      svc   = (m_pend || (flush && finish)) && (n > 0) && acc;
      if (fillp || svc) begin
        if (acc) begin
          l.data = '0;
          for (int k = 0; k < n; k++) l.data[32*k +: 32] = asmq[k];
          l.words = n; l.ovf = m_ovf; l.nar = m_nar;
          sb.push_back(l);
          mcount++;
        end else m_err = 1;
        asmq.delete(); m_ovf = 0; m_nar = 0; m_pend = 0;
      end else begin
        m_pend = (m_pend || flush) && (n > 0);
      end
      if (pop) begin
        mcount--;
        m_lines++;
      end
    end
  end

  // Monitor: status every cycle, head line retired on each handshake.
  always @(negedge clk) begin : monitor
    line_t l;
    chk("line_valid", LW'(line_valid), LW'(mcount > 0));
    chk("full", LW'(full), LW'(mcount == DEPTH));
    chk("err", LW'(err), LW'(m_err));
    chk("lines_out", LW'(lines_out), LW'(m_lines));
    if (line_valid && line_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected got=line exp=none t=%0t", $time);
      end else begin
        l = sb.pop_front();
        chk("line_data", line_data, l.data);
        chk("line_words", LW'(line_words), LW'(l.words));
        chk("line_ovf", LW'(line_ovf), LW'(l.ovf));
        chk("line_nar", LW'(line_nar), LW'(l.nar));
      end
    end else if (mcount == 0) begin
      chk("empty_data", line_data, '0);
      chk("empty_words", LW'(line_words), '0);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(bit f, logic [31:0] u, bit ov, bit fl);
    finish = f; unum = u; overflow = ov; flush = fl;
    cyc();
    finish = 0; unum = '0; overflow = 0; flush = 0;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, '0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; idle(2); rst = 0;
  endtask

  task automatic rand_line();
    for (int i = 0; i < LANES; i++) drive(1, $urandom, 0, 0);
  endtask

  initial begin
    line_ready = 1;
    do_reset();
    chk("rst_valid", LW'(line_valid), '0);
    chk("rst_lines", LW'(lines_out), '0);

    // sequential fill
    for (int i = 1; i <= LANES; i++) drive(1, 32'(i), 0, 0);
    idle(3);
    chk("seq_lines", LW'(lines_out), LW'(1));

    // status flags, then a clean line
    for (int i = 1; i <= LANES; i++)
      drive(1, (i == 9) ? 32'h8000_0000 : 32'(i), i == 5, 0);
    for (int i = 1; i <= LANES; i++) drive(1, 32'h1000 + 32'(i), 0, 0);
    idle(3);

    // flush partial line, then flush with nothing assembled
    for (int i = 0; i < 5; i++) drive(1, 32'hA0 + 32'(i), 0, 0);
    drive(0, '0, 0, 1);
    idle(3);
    drive(0, '0, 0, 1);
    idle(3);
    chk("flush_lines", LW'(lines_out), LW'(4));

    // overrun
    do_reset();
    line_ready = 0;
    repeat (5) rand_line();
    idle(2);
    chk("ovr_full", LW'(full), LW'(1));
    chk("ovr_err", LW'(err), LW'(1));
    line_ready = 1;
    idle(8);
    chk("ovr_lines", LW'(lines_out), LW'(4));
    chk("ovr_err_hold", LW'(err), LW'(1));

    // push/pop collision on a full FIFO
    do_reset();
    line_ready = 0;
    repeat (4) rand_line();
    for (int i = 0; i < LANES - 1; i++) drive(1, $urandom, 0, 0);
    line_ready = 1;
    drive(1, 32'hC0DE, 0, 0);
    line_ready = 0;
    chk("col_err", LW'(err), '0);
    chk("col_full", LW'(full), LW'(1));
    line_ready = 1;
    idle(8);

    // reset mid-line
    for (int i = 0; i < 7; i++) drive(1, 32'h55 + 32'(i), 1, 0);
    do_reset();
    for (int i = 0; i < LANES; i++) drive(1, 32'h100 + 32'(i), 0, 0);
    idle(3);
    chk("rml_lines", LW'(lines_out), LW'(1));

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int pr;
      if (c % 200 == 0) pr = $urandom_range(10, 100);
      line_ready = ($urandom_range(0, 99) < pr);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else drive($urandom_range(0, 99) < 70,
                 ($urandom_range(0, 19) == 0) ? 32'h8000_0000 : $urandom,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 19) == 0);
    end
    line_ready = 1;
    drive(0, '0, 0, 1);
    idle(12);
    chk("drained", LW'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
